dm_cache_read_core: RTL and testbench

- Direct-mapped, read-only cache core that sits directly downstream of cpu_translator.
- Consumes its core request port (core_req_*) and returns core_resp_* data.
- On a miss, refills one full line from a simple single-outstanding memory port (mem_*).
- Hits are served from local tag/data arrays with fixed 2-cycle latency.

---
 rtl/dm_cache_read_core.sv | 183 ++++++++++++++++++
 tb/tb_dm_cache_read_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_read_core.sv
// dm_cache_read_core
// ------------------
// Direct-mapped, read-only cache core. It accepts one word read at a time
// from the core, serves hits from local tag/data storage with a 2-cycle
// latency, and on a miss refills the whole line (word 0 upward) through a
// single-outstanding word-read memory port.
//
// Optional build macro: DM_CACHE_STATS_EN adds saturating hit/miss counters
// on the stat_hits / stat_misses outputs.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   core_req_valid/ready  core read request handshake (ready only when idle)
//   core_req_addr         byte address, bits [1:0] ignored
//   core_resp_valid/data  one-cycle response pulse; data held until next pulse
//   mem_req_valid/ready   word-read request to memory
//   mem_req_addr          word-aligned refill address
//   mem_resp_valid/data   memory read data, one pulse per accepted request
//   stat_hits/misses      (DM_CACHE_STATS_EN only) saturating event counters
module dm_cache_read_core #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 2 - WO_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } state_t;

  state_t state_reg, state_next;

  // Word address of the request in flight (byte offset dropped).
  logic [ADDR_W-3:0] addr_reg;
  logic [WO_W-1:0]   beat_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [DATA_W-1:0] resp_data_reg;

  // Tag and data storage carry no reset; validity lives in valid_reg.
  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_W-1:0] data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WO_W-1:0]  req_wo;
  logic             hit;
  logic             last_beat;
  logic             accept;
  logic             refill_wr;
  logic             byte_off_unused;

  assign req_tag   = addr_reg[ADDR_W-3 -: TAG_W];
  assign req_idx   = addr_reg[WO_W +: IDX_W];
  assign req_wo    = addr_reg[WO_W-1:0];
  assign hit       = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = (beat_reg == WO_W'(LINE_WORDS - 1));
  assign accept    = core_req_valid && core_req_ready;
  // A response arriving on the same edge as reset must not land in storage.
  assign refill_wr = (state_reg == MISS_WAIT) && mem_resp_valid && !rst;
  assign byte_off_unused = ^core_req_addr[1:0];

  // Next state and outputs. Memory handshakes are only looked at in the
  // states that own them, so strays elsewhere have no effect.
  always_comb begin
    state_next      = state_reg;
    core_req_ready  = 1'b0;
    core_resp_valid = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    core_resp_data  = resp_data_reg;

    case (state_reg)
      IDLE: begin
        core_req_ready = !rst;
        if (accept) state_next = LOOKUP;
      end
      LOOKUP: begin
        state_next = hit ? RESP : MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = !rst;
        mem_req_addr  = rst ? '0 : {req_tag, req_idx, beat_reg, 2'b00};
        if (mem_req_ready) state_next = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid) state_next = last_beat ? RESP : MISS_REQ;
      end
      RESP: begin
        core_resp_valid = !rst;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      beat_reg      <= '0;
      valid_reg     <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) addr_reg <= core_req_addr[ADDR_W-1:2];
        end
        LOOKUP: begin
          if (hit) begin
            resp_data_reg <= data_mem[{req_idx, req_wo}];
          end else begin
            // Invalidate up front so an abandoned refill leaves no stale line.
            valid_reg[req_idx] <= 1'b0;
            beat_reg           <= '0;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            if (beat_reg == req_wo) resp_data_reg <= mem_resp_data;
            if (last_beat) valid_reg[req_idx] <= 1'b1;
            else           beat_reg <= beat_reg + WO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_mem[{req_idx, beat_reg}] <= mem_resp_data;
      if (last_beat) tag_mem[req_idx] <= req_tag;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hits_reg, misses_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else if (state_reg == LOOKUP) begin
      if (hit) begin
        if (hits_reg != 32'hFFFF_FFFF) hits_reg <= hits_reg + 32'd1;
      end else begin
        if (misses_reg != 32'hFFFF_FFFF) misses_reg <= misses_reg + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_reg;
  assign stat_misses = misses_reg;
`endif

endmodule

// File: tb/tb_dm_cache_read_core.sv
// Testbench for dm_cache_read_core: directed reads against a memory model
// that returns addr ^ 32'hA5A50000 one cycle after each accepted request.
module tb_dm_cache_read_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_req_addr;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_log[$];
  bit          pend   = 1'b0;
  bit          inject = 1'b0;
  logic [31:0] resp_word = '0;
  logic [31:0] stall_addr = 32'h0000_0208;

  always #5 clk = ~clk;

  dm_cache_read_core #(
    .ADDR_W(32), .DATA_W(32), .NUM_LINES(16), .LINE_WORDS(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_req_addr  (core_req_addr),
    .core_resp_valid(core_resp_valid),
    .core_resp_data (core_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef DM_CACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  // Memory model: evaluated just after the falling edge so it sees the
  // ready value the stimulus set on that edge.
  always begin
    @(negedge clk);
    #1;
    mem_resp_valid = pend | inject;
    mem_resp_data  = inject ? 32'hDEAD_BEEF : resp_word;
    pend = 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      pend      = 1'b1;
      resp_word = mem_req_addr ^ 32'hA5A5_0000;
      mem_log.push_back(mem_req_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one read from a falling edge and follow it to its response.
  // exp_lat < 0 skips the latency check; stall holds mem_req_ready low for
  // five cycles when the request for stall_addr first appears.
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input int exp_beats, input int exp_lat, input bit stall);
    int lat;
    bit seen;
    bit stalled;
    logic [31:0] data;
    mem_log.delete();
    check("req_ready", core_req_ready, 1);
    core_req_valid = 1'b1;
    core_req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    core_req_valid = 1'b0;
    core_req_addr  = 32'hFFFF_FFFC;
    lat = 1; seen = 0; stalled = 0; data = '0;
    while (!seen && lat < 200) begin
      if (stall && !stalled && mem_req_valid && mem_req_addr == stall_addr) begin
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          check("stall_valid", mem_req_valid, 1);
          check("stall_addr", mem_req_addr, stall_addr);
          check("stall_core_ready", core_req_ready, 0);
          @(negedge clk);
          lat++;
        end
        mem_req_ready = 1'b1;
        stalled = 1;
      end
      if (core_resp_valid) begin
        seen = 1;
        data = core_resp_data;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check("resp_seen", seen, 1);
    check("resp_data", data, exp_data);
    if (exp_lat >= 0) check("resp_latency", lat, exp_lat);
    if (stall) check("stall_done", stalled, 1);
    @(negedge clk);
    check("resp_single_pulse", core_resp_valid, 0);
    check("resp_data_hold", core_resp_data, exp_data);
    check("mem_beats", mem_log.size(), exp_beats);
    for (int i = 0; i < mem_log.size() && i < exp_beats; i++)
      check("mem_addr", mem_log[i], (a & 32'hFFFF_FFF0) + 32'(4 * i));
    $display("txn addr=%h data=%h latency=%0d beats=%0d", a, data, lat, mem_log.size());
  endtask

  initial begin
    int k;
    rst            = 1'b1;
    core_req_valid = 1'b0;
    core_req_addr  = '0;
    mem_req_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_core_ready", core_req_ready, 0);
    rst = 1'b0;
    #1;
    check("reset_resp_valid", core_resp_valid, 0);
    check("reset_resp_data", core_resp_data, 0);
    check("reset_mem_valid", mem_req_valid, 0);
    check("reset_mem_addr", mem_req_addr, 0);

    do_read(32'h0000_0104, 32'hA5A5_0104, 4, 10, 0);   // cold miss
    do_read(32'h0000_0108, 32'hA5A5_0108, 0, 2, 0);    // hit in refilled line
    do_read(32'h0000_1100, 32'hA5A5_1100, 4, 10, 0);   // conflict, new tag
    do_read(32'h0000_0100, 32'hA5A5_0100, 4, 10, 0);   // evicted line misses again
    do_read(32'h0000_0200, 32'hA5A5_0200, 4, -1, 1);   // stall on beat 2 (0x208)
    do_read(32'h0000_020C, 32'hA5A5_020C, 0, 2, 0);    // line from stalled refill

    // Reset in the middle of a refill of 0x104 (index 0 now holds tag 2).
    mem_log.delete();
    core_req_valid = 1'b1;
    core_req_addr  = 32'h0000_0104;
    @(posedge clk);
    @(negedge clk);
    core_req_valid = 1'b0;
    k = 0;
    while (!mem_req_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("refill_started", mem_req_valid, 1);
    @(negedge clk);   // now waiting for beat 0 data
    rst = 1'b1;
    #1;
    check("rst_mid_core_ready", core_req_ready, 0);
    @(negedge clk);
    rst    = 1'b0;
    inject = 1'b1;
    #1;
    check("rst_mid_resp_valid", core_resp_valid, 0);
    check("rst_mid_resp_data", core_resp_data, 0);
    check("rst_mid_mem_valid", mem_req_valid, 0);
    check("rst_mid_mem_addr", mem_req_addr, 0);
    check("rst_mid_core_ready_after", core_req_ready, 1);
    @(negedge clk);
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_mem_valid", mem_req_valid, 0);
      check("stray_resp_valid", core_resp_valid, 0);
      @(negedge clk);
    end
    $display("txn reset mid-refill addr=00000104");

    do_read(32'h0000_0104, 32'hA5A5_0104, 4, 10, 0);   // full refill after reset
    do_read(32'h0000_0108, 32'hA5A5_0108, 0, 2, 0);
    do_read(32'h0000_010C, 32'hA5A5_010C, 0, 2, 0);
`ifdef DM_CACHE_STATS_EN
    check("stat_misses", stat_misses, 1);
    check("stat_hits", stat_hits, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stat_misses_rst", stat_misses, 0);
    check("stat_hits_rst", stat_hits, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
